// File: rtl/exp4_pkg.sv
// Shared constants for the exp4 datapath: default widths and the stored
// sequence the player has to reproduce.
package exp4_pkg;

    localparam int N_DEFAULT = 4;
    localparam int M_DEFAULT = 4;
    localparam int ROM_DEPTH = 16;

    localparam logic [3:0] ROM_TABLE [ROM_DEPTH] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
    };

endpackage

// File: rtl/exp4_fluxo_dados_edge_detector.sv
// Rising-activity detector: one-cycle pulse when sinal goes low -> high.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) prev <= 1'b0;
        else       prev <= sinal;
    end

    assign pulso = sinal & ~prev & ~reset;

endmodule

// File: rtl/exp4_fluxo_dados.sv
// exp4 datapath: address counter, sequence ROM, switch register, comparator
// and switch-activity pulse, driven by the exp4 control unit.
module exp4_fluxo_dados
    import exp4_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zeraC,
    input  logic         contaC,
    input  logic         zeraR,
    input  logic         registraR,
    input  logic [N-1:0] chaves,
    output logic         igual,
    output logic         fimC,
    output logic         tem_jogada,
    output logic [M-1:0] db_contagem,
    output logic [N-1:0] db_memoria,
    output logic [N-1:0] db_chaves
);

    always_ff @(posedge clock) begin
        if (reset)       db_contagem <= '0;
        else if (zeraC)  db_contagem <= '0;
        else if (contaC) db_contagem <= db_contagem + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)          db_chaves <= '0;
        else if (zeraR)     db_chaves <= '0;
        else if (registraR) db_chaves <= chaves;
    end

    // NOTE: only the ROM output register is reset; the table itself is constant and needs no reset.
    always_ff @(posedge clock) begin
        if (reset) db_memoria <= '0;
        else       db_memoria <= N'(ROM_TABLE[db_contagem]);
    end

    assign igual = (db_memoria == db_chaves);
    assign fimC  = (db_contagem == {M{1'b1}});

    edge_detector u_jogada (
        .clock (clock),
        .reset (reset),
        .sinal (|chaves),
        .pulso (tem_jogada)
    );

endmodule

// File: tb/tb_exp4_fluxo_dados.sv
// Self-checking bench for exp4_fluxo_dados: vector table plus directed
// sequences for counter wrap, clear priority and the activity pulse.
module tb_exp4_fluxo_dados;

    logic       clock = 1'b0;
    logic       reset, zeraC, contaC, zeraR, registraR;
    logic [3:0] chaves;
    logic       igual, fimC, tem_jogada;
    logic [3:0] db_contagem, db_memoria, db_chaves;

    int passed = 0;
    int total  = 0;

    exp4_fluxo_dados dut (
        .clock       (clock),
        .reset       (reset),
        .zeraC       (zeraC),
        .contaC      (contaC),
        .zeraR       (zeraR),
        .registraR   (registraR),
        .chaves      (chaves),
        .igual       (igual),
        .fimC        (fimC),
        .tem_jogada  (tem_jogada),
        .db_contagem (db_contagem),
        .db_memoria  (db_memoria),
        .db_chaves   (db_chaves)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst, zc, cc, zr, rr;
        logic [3:0] ch;
        logic [3:0] e_cnt, e_mem, e_chv;
        logic       e_igual, e_fim, e_tem;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic drive(input logic rst, zc, cc, zr, rr, input logic [3:0] ch);
        reset = rst; zeraC = zc; contaC = cc; zeraR = zr; registraR = rr; chaves = ch;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    int pulses;

    initial begin
        drive(1, 0, 1, 0, 1, 4'd5);

        //          rst zc cc zr rr ch    cnt mem chv  ig fim tem
        vecs[0]  = '{1, 0, 1, 0, 1, 4'd5, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{1, 0, 1, 0, 1, 4'd5, 0, 0, 0, 1, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 0, 4'd0, 0, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 1, 0, 0, 4'd0, 1, 1, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 1, 0, 0, 4'd0, 2, 2, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 1, 0, 0, 4'd0, 3, 4, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 4'd0, 3, 8, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 4'd0, 0, 8, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 1, 4'd1, 0, 1, 1, 1, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 4'd1, 0, 1, 1, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 1, 4'd2, 0, 1, 2, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 1, 1, 4'd2, 0, 1, 0, 0, 0, 0};
        vecs[12] = '{0, 0, 1, 0, 0, 4'd2, 1, 1, 0, 0, 0, 0};
        vecs[13] = '{1, 0, 1, 0, 1, 4'd3, 0, 0, 0, 1, 0, 0};

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].zc, vecs[i].cc, vecs[i].zr, vecs[i].rr, vecs[i].ch);
            step();
            check($sformatf("v%0d cnt", i),   db_contagem, vecs[i].e_cnt);
            check($sformatf("v%0d mem", i),   db_memoria,  vecs[i].e_mem);
            check($sformatf("v%0d chv", i),   db_chaves,   vecs[i].e_chv);
            check($sformatf("v%0d igual", i), igual,       vecs[i].e_igual);
            check($sformatf("v%0d fim", i),   fimC,        vecs[i].e_fim);
            check($sformatf("v%0d tem", i),   tem_jogada,  vecs[i].e_tem);
        end

        // Counter runs to the last address, flags it, then wraps silently.
        drive(0, 0, 1, 0, 0, 4'd0);
        for (int i = 1; i <= 15; i++) begin
            step();
            if (i == 14) check("wrap fim@14", fimC, 0);
        end
        check("wrap cnt@15", db_contagem, 15);
        check("wrap fim@15", fimC, 1);
        drive(0, 0, 0, 0, 0, 4'd0);
        step();
        check("wrap mem@15", db_memoria, 4);
        drive(0, 0, 1, 0, 0, 4'd0);
        step();
        check("wrap cnt@0", db_contagem, 0);
        check("wrap fim@0", fimC, 0);

        // Clear beats increment/load on the same edge.
        for (int i = 0; i < 7; i++) step();
        check("prio cnt@7", db_contagem, 7);
        drive(0, 1, 1, 0, 0, 4'd0);
        step();
        check("prio zeraC", db_contagem, 0);
        drive(0, 0, 0, 0, 1, 4'd9);
        step();
        check("prio load", db_chaves, 9);
        drive(0, 0, 0, 1, 1, 4'd6);
        step();
        check("prio zeraR", db_chaves, 0);

        // Activity pulse: one cycle per zero -> non-zero transition.
        drive(0, 0, 0, 0, 0, 4'd0);
        step();
        chaves = 4'd4;
        #1;
        check("jog first", tem_jogada, 1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) #1;
            if (tem_jogada) pulses++;
            step();
        end
        check("jog pulses1", pulses, 1);
        chaves = 4'd0;
        step();
        step();
        chaves = 4'd2;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (tem_jogada) pulses++;
            step();
        end
        check("jog pulses2", pulses, 1);

        // Pulse stays low while reset is asserted.
        chaves = 4'd0;
        step();
        reset  = 1'b1;
        chaves = 4'd7;
        #1;
        check("jog in reset", tem_jogada, 0);
        step();
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
